// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data load/store port and memory-side signals
// around the shared single-port memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_addr, mem_we, mem_din, busy
  );

  // Requesters and memory array side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_addr, mem_we, mem_din, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory between the
// instruction-fetch port and the data port, via a fixed IDLE/ACCESS/RESP sequence.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_TOP = 16384
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Port select encoding: 0 = fetch, 1 = data.
  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  state_t            state, state_n;
  logic              last_grant;
  logic              sel_q, we_q, err_q;

  logic              grant_c, gnt_sel_c, gnt_we_c, gnt_err_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic [DATA_W-1:0] gnt_wdata_c;

  logic              if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_we_q, busy_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state, arbitration and the request fields captured on grant.
  always_comb begin
    state_n     = state;
    grant_c     = 1'b0;
    gnt_sel_c   = SEL_FETCH;
    gnt_addr_c  = bus.if_addr;
    gnt_wdata_c = '0;
    gnt_we_c    = 1'b0;
    gnt_err_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_c = 1'b1;
          state_n = ACCESS;
          // On a tie the port that was not served last wins.
          if (bus.if_req && bus.d_req) gnt_sel_c = ~last_grant;
          else                         gnt_sel_c = bus.d_req;
        end
      end
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (gnt_sel_c == SEL_DATA) begin
      gnt_addr_c  = bus.d_addr;
      gnt_wdata_c = bus.d_wdata;
      gnt_we_c    = bus.d_we;
    end
    gnt_err_c = (gnt_addr_c > ADDR_W'(MEM_TOP));
  end

  // Datapath: latch on grant, drive memory during ACCESS, respond in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= SEL_DATA;
      sel_q      <= SEL_FETCH;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      busy_q   <= (state_n != IDLE);
      // Write strobe is high only for the ACCESS cycle following a grant.
      mem_we_q <= grant_c & gnt_we_c & ~gnt_err_c;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if (grant_c) begin
        sel_q      <= gnt_sel_c;
        we_q       <= gnt_we_c;
        err_q      <= gnt_err_c;
        mem_addr_q <= gnt_addr_c;
        mem_din_q  <= gnt_wdata_c;
      end
      if (state == ACCESS) begin
        if (sel_q == SEL_FETCH) begin
          if_ack_q   <= 1'b1;
          if_err_q   <= err_q;
          if_rdata_q <= (err_q || we_q) ? '0 : bus.mem_dout;
        end else begin
          d_ack_q    <= 1'b1;
          d_err_q    <= err_q;
          d_rdata_q  <= (err_q || we_q) ? '0 : bus.mem_dout;
        end
      end
      if (state == RESP) last_grant <= sel_q;
    end
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.if_err   = if_err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  logic init_mem;
  int   tests;
  int   fails;

  logic [31:0] mem [64];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_TOP(16384)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word i holds i after init; only the low 6 index bits are decoded.
  assign bus.mem_dout = mem[bus.mem_addr[5:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset_n     = 1'b0;
    init_mem    = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    init_mem = 1'b0;
    reset_n  = 1'b1;

    // Fetch read of word 8
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd8;
    @(negedge clk);
    chk("f8_mem_addr", bus.mem_addr, 32'd8);
    chk("f8_busy_acc", 32'(bus.busy), 32'd1);
    chk("f8_mem_we", 32'(bus.mem_we), 32'd0);
    chk("f8_ack_early", 32'(bus.if_ack), 32'd0);
    @(negedge clk);
    chk("f8_if_ack", 32'(bus.if_ack), 32'd1);
    chk("f8_if_rdata", bus.if_rdata, 32'd8);
    chk("f8_if_err", 32'(bus.if_err), 32'd0);
    chk("f8_d_ack", 32'(bus.d_ack), 32'd0);
    chk("f8_busy_resp", 32'(bus.busy), 32'd1);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f8_busy_idle", 32'(bus.busy), 32'd0);
    chk("f8_ack_drop", 32'(bus.if_ack), 32'd0);

    // Data write of 0xDEADBEEF to 40, then read back
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd40;
    bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("w40_mem_we", 32'(bus.mem_we), 32'd1);
    chk("w40_mem_addr", bus.mem_addr, 32'd40);
    chk("w40_mem_din", bus.mem_din, 32'hDEADBEEF);
    @(negedge clk);
    chk("w40_mem_we_off", 32'(bus.mem_we), 32'd0);
    chk("w40_d_ack", 32'(bus.d_ack), 32'd1);
    chk("w40_d_err", 32'(bus.d_err), 32'd0);
    chk("w40_d_rdata", bus.d_rdata, 32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("w40_mem", mem[40], 32'hDEADBEEF);
    chk("w40_ack_drop", 32'(bus.d_ack), 32'd0);
    bus.d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("r40_d_ack", 32'(bus.d_ack), 32'd1);
    chk("r40_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_req = 1'b0;
    @(negedge clk);

    // Contention: both held, fetch wins first, then strict alternation
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd4;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd12;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("cont_if_ack_%0d", k), 32'(bus.if_ack), 32'((k % 6) == 2));
      chk($sformatf("cont_d_ack_%0d", k), 32'(bus.d_ack), 32'((k % 6) == 5));
      if ((k % 6) == 2) chk($sformatf("cont_if_rdata_%0d", k), bus.if_rdata, 32'd4);
      if ((k % 6) == 5) chk($sformatf("cont_d_rdata_%0d", k), bus.d_rdata, 32'd12);
      if (k == 12) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end

    // Out-of-range data write is suppressed
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd16385;
    bus.d_wdata = 32'h00001234;
    @(negedge clk);
    chk("oor_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("oor_d_ack", 32'(bus.d_ack), 32'd1);
    chk("oor_d_err", 32'(bus.d_err), 32'd1);
    chk("oor_d_rdata", bus.d_rdata, 32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("oor_mem1", mem[1], 32'd1);

    // Fetch at MEM_TOP is legal, one past it is an error
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd16384;
    @(negedge clk);
    @(negedge clk);
    chk("top_if_ack", 32'(bus.if_ack), 32'd1);
    chk("top_if_err", 32'(bus.if_err), 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd16385;
    @(negedge clk);
    @(negedge clk);
    chk("top1_if_ack", 32'(bus.if_ack), 32'd1);
    chk("top1_if_err", 32'(bus.if_err), 32'd1);
    chk("top1_if_rdata", bus.if_rdata, 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Reset during the ACCESS cycle of a write
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd30;
    bus.d_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("rmid_mem_we_pre", 32'(bus.mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rmid_busy", 32'(bus.busy), 32'd0);
    chk("rmid_d_ack", 32'(bus.d_ack), 32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rmid_d_ack_after", 32'(bus.d_ack), 32'd0);
    chk("rmid_busy_after", 32'(bus.busy), 32'd0);
    chk("rmid_mem30", mem[30], 32'd30);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd8;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'd12;
    @(negedge clk);
    chk("rpost_mem_addr", bus.mem_addr, 32'd8);
    @(negedge clk);
    chk("rpost_if_ack", 32'(bus.if_ack), 32'd1);
    chk("rpost_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rpost_if_rdata", bus.if_rdata, 32'd8);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);

    // Inputs changed during ACCESS are ignored
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd20;
    bus.d_wdata = 32'h00000055;
    @(negedge clk);
    chk("hold_mem_addr", bus.mem_addr, 32'd20);
    chk("hold_mem_we", 32'(bus.mem_we), 32'd1);
    bus.d_addr  = 32'd24;
    bus.d_wdata = 32'h00000066;
    @(negedge clk);
    chk("hold_mem_addr_resp", bus.mem_addr, 32'd20);
    chk("hold_d_ack", 32'(bus.d_ack), 32'd1);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("hold_mem20", mem[20], 32'h00000055);
    chk("hold_mem24", mem[24], 32'd24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, combinational-read, 32-bit-word memory between the instruction-fetch port (read-only) and the data load/store port (read/write).
- Requests use a req/ack handshake. Requesters are arbitrated round-robin.
- Each access is sequenced through a fixed 3-state FSM, so every transaction has the same registered timing.
- Sits between the CPU front end / LSU and the memory array. The address is passed through unchanged as the memory index.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MEM_TOP, 16384, highest legal memory index; any address > MEM_TOP is an error.

Ports:
- clk  in  1  system clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1.
- if_err  out  1  fetch address out of range; valid while if_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  DATA_W  data read data; valid while d_ack=1.
- d_err  out  1  data address out of range; valid while d_ack=1.
- mem_addr  out  ADDR_W  memory index.
- mem_we  out  1  memory write enable.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory combinational read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, last_grant=DATA (so fetch wins the first tie).
  - All ack/err outputs 0, if_rdata/d_rdata 0, mem_addr 0, mem_we 0, mem_din 0, busy 0.
  - Reset mid-transaction aborts immediately: mem_we drops asynchronously, no ack is ever issued for the aborted request, and no partial write beyond the current cycle occurs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port that is not last_grant (round-robin).
  - On grant, latch sel, addr, we, wdata into internal registers; go to ACCESS. For fetch, we is forced to 0.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - mem_din = latched wdata.
  - mem_we = latched we AND in-range.
  - At the clock edge, capture mem_dout into the selected port's rdata register (0 if out of range, or if the access is a write).
  - Set the err flag; go to RESP.
- RESP (exactly 1 cycle):
  - Selected port's ack=1 and err valid; the other port's ack stays 0.
  - last_grant <= sel; go to IDLE.
- Outside ACCESS: mem_we=0; mem_addr/mem_din hold their last values.
- Latency: req sampled in IDLE at cycle N -> memory access in cycle N+1 -> ack in cycle N+2. Peak throughput is one access per 3 cycles.
- The requester may change req/addr in the cycle after ack. Arbitration re-samples in IDLE, so back-to-back requests from the same port alternate with a waiting peer.
- Input changes during ACCESS/RESP are ignored; the latched values are used.
- Range check is addr > MEM_TOP, evaluated on the latched address with an unsigned compare.
- Error writes are suppressed: memory is unchanged, err=1, rdata=0.
- rdata and err registers keep their values after ack drops; they are meaningful only while ack=1.
- A port whose req drops before grant is simply not serviced. There is no queueing.

Test Plan:
- Fetch read: mem[8]=8; if_req=1, if_addr=8 in IDLE -> mem_addr=8 on cycle+1; if_ack=1, if_rdata=8, if_err=0 on cycle+2; busy high for 2 cycles.
- Data write then read: d_we=1, d_addr=40, d_wdata=0xDEADBEEF -> mem_we high for exactly 1 cycle, d_ack on cycle+2. Then a read of 40 -> d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held high from reset, addrs 4 and 12 -> grants alternate fetch, data, fetch, data. The acks are 3 cycles apart and never overlap.
- Out of range: d_we=1, d_addr=16385 -> mem_we stays 0, d_ack=1, d_err=1, d_rdata=0. Fetch at 16384 -> if_err=0.
- Reset mid-op: assert reset_n=0 during ACCESS of a write -> mem_we falls immediately, busy=0, no ack. After release, the next request is serviced normally with fetch winning a tie.
- Held inputs: change d_addr from 20 to 24 during ACCESS -> the access still uses 20; mem[24] is untouched.
